switch_debounce_filter: RTL

//  Debounces the raw board push-switches before they reach the switch-to-LED logic.
//  Per channel:
//   - 2-flop synchronizer, then an integrating stability counter.
//   - Registered clean level out, plus one-cycle rise/fall event pulses.

---
 rtl/switch_debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 63 ++++++
 rtl/switch_debounce_filter.sv | 45 ++++
 3 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared defaults and helpers for the switch debounce filter.
package switch_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int DEFAULT_NUM_SWITCHES   = 4;

    // Bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, integrating stability counter,
// registered clean level and one-cycle rise/fall pulses.
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int               CNT_W    = clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the accepted level discards the accumulated count.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_fall  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_Switch = r_level;
    assign o_Rise   = r_rise;
    assign o_Fall   = r_fall;

endmodule

// File: rtl/switch_debounce_filter.sv
// Debounce filter for the board push-switches, one debounce_channel per switch.
// Optional macro SWITCH_TOGGLE_EN adds a per-channel toggle latch output o_Toggle.
module switch_debounce_filter
    import switch_debounce_pkg::*;
#(
    parameter int NUM_SWITCHES   = DEFAULT_NUM_SWITCHES,
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
`ifdef SWITCH_TOGGLE_EN
    output logic [NUM_SWITCHES-1:0] o_Toggle,
`endif
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Rise,
    output logic [NUM_SWITCHES-1:0] o_Fall
);

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : gen_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_channel (
            .i_Clk   (i_Clk),
            .i_Rst_L (i_Rst_L),
            .i_Switch(i_Switch[g]),
            .o_Switch(o_Switch[g]),
            .o_Rise  (o_Rise[g]),
            .o_Fall  (o_Fall[g])
        );
    end

`ifdef SWITCH_TOGGLE_EN
    logic [NUM_SWITCHES-1:0] r_toggle;

    // Flips the cycle after each debounced press.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_toggle <= '0;
        else          r_toggle <= r_toggle ^ o_Rise;
    end

    assign o_Toggle = r_toggle;
`endif

endmodule
